// File: rtl/inst_decode.sv
// Instruction decoder: registers the 62-bit instruction word into per-memory control
// fields, tracks the active phase, counts kernel-load/execute beats and latches protocol errors.
module inst_decode #(
   parameter int col = 8,
   parameter int nij = 36
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [61:0] inst,
   output logic [6:0]  dec_ctrl,
   output logic [12:0] dec_xmem,
   output logic [13:0] dec_pmem,
   output logic [25:0] dec_wmem,
   output logic [1:0]  dec_mode,
   output logic [2:0]  phase,
   output logic [3:0]  load_cnt,
   output logic [5:0]  exec_cnt,
   output logic [2:0]  err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      XWR    = 3'd1,
      WLD    = 3'd2,
      KLD    = 3'd3,
      XFL    = 3'd4,
      EXE    = 3'd5,
      ACC    = 3'd6,
      UNUSED = 3'd7
   } phase_t;

   localparam logic [3:0] col_target = 4'(col);
   localparam logic [5:0] nij_target = 6'(nij);

   phase_t     state;
   phase_t     next_state;
   phase_t     cls;
   logic [3:0] load_base;
   logic [3:0] load_next;
   logic [5:0] exec_base;
   logic [5:0] exec_next;
   logic       kload_fail;
   logic       exec_fail;
   logic       conflict;

   logic load, execute, l0_wr, l0_rd, start_acc, acc;
   logic cen_x, wen_x, cen_w0, wen_w0, cen_w1, wen_w1;

   assign load      = inst[0];
   assign execute   = inst[1];
   assign l0_wr     = inst[2];
   assign l0_rd     = inst[3];
   assign start_acc = inst[60];
   assign acc       = inst[33];
   assign cen_x     = inst[19];
   assign wen_x     = inst[18];
   assign cen_w1    = inst[37];
   assign wen_w1    = inst[36];
   assign cen_w0    = inst[35];
   assign wen_w0    = inst[34];

   assign phase = state;

   // Priority-resolve this cycle's activity, decide the next phase, and compute
   // counter updates and error conditions from the current instruction word.
   always_comb begin
      cls        = IDLE;
      next_state = IDLE;
      load_base  = 4'd0;
      load_next  = load_cnt;
      exec_base  = 6'd0;
      exec_next  = exec_cnt;

      if (start_acc || acc)                  cls = ACC;
      else if (execute)                      cls = EXE;
      else if (load)                         cls = KLD;
      else if (!cen_x && wen_x)              cls = XFL;
      else if (!cen_x && !wen_x)             cls = XWR;
      else if (!cen_w0 || !cen_w1)           cls = WLD;

      // A trailing L0 write keeps a weight load or xmem fill alive for one more cycle
      if (state == UNUSED)
         next_state = IDLE;
      else if (cls == IDLE && l0_wr && (state == WLD || state == XFL))
         next_state = state;
      else
         next_state = cls;

      if (next_state == KLD) begin
         load_base = (state == KLD) ? load_cnt : 4'd0;
         load_next = (load && load_base != 4'd15) ? load_base + 4'd1 : load_base;
      end
      if (next_state == EXE) begin
         exec_base = (state == EXE) ? exec_cnt : 6'd0;
         exec_next = (execute && exec_base != 6'd63) ? exec_base + 6'd1 : exec_base;
      end

      kload_fail = (state == KLD) && (next_state != KLD) && (load_cnt != col_target);
      exec_fail  = (state == EXE) && (next_state != EXE) && (exec_cnt != nij_target);
      conflict   = (load && execute)
                || (!cen_w0 && !wen_w0 && !cen_w1 && !wen_w1)
                || (l0_rd && l0_wr && state == XFL);
   end

   // Decoded fields are a straight one-cycle register of the instruction; errors accumulate until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_ctrl <= 7'd0;
         dec_xmem <= {2'b11, 11'd0};
         dec_pmem <= {1'b0, 2'b11, 11'd0};
         dec_wmem <= {22'd0, 4'b1111};
         dec_mode <= 2'd0;
         state    <= IDLE;
         load_cnt <= 4'd0;
         exec_cnt <= 6'd0;
         err      <= 3'd0;
      end else begin
         dec_ctrl <= inst[6:0];
         dec_xmem <= inst[19:7];
         dec_pmem <= inst[33:20];
         dec_wmem <= inst[59:34];
         dec_mode <= inst[61:60];
         state    <= next_state;
         load_cnt <= load_next;
         exec_cnt <= exec_next;
         err      <= err | {exec_fail, kload_fail, conflict};
      end
   end

endmodule

// File: tb/tb_inst_decode.sv
// Directed self-checking bench for inst_decode: phase tracking, beat counters,
// sticky error flags and one-cycle field registration.
module tb_inst_decode;

   logic        clk;
   logic        reset;
   logic [61:0] inst;
   logic [6:0]  dec_ctrl;
   logic [12:0] dec_xmem;
   logic [13:0] dec_pmem;
   logic [25:0] dec_wmem;
   logic [1:0]  dec_mode;
   logic [2:0]  phase;
   logic [3:0]  load_cnt;
   logic [5:0]  exec_cnt;
   logic [2:0]  err;

   int checks   = 0;
   int failures = 0;

   // All CEN/WEN deasserted: no memory activity, class none
   localparam logic [61:0] IDLE_I  = 62'h3D_800C_0000;
   localparam logic [61:0] LOAD_I  = IDLE_I | 62'h1;
   localparam logic [61:0] EXEC_I  = IDLE_I | 62'hA;
   localparam logic [61:0] XFL_I   = (IDLE_I & ~(62'd1 << 19)) | 62'h4;
   localparam logic [61:0] TRAIL_I = IDLE_I | 62'h4;
   localparam logic [61:0] XWR_I   = IDLE_I & ~(62'h3 << 18);
   localparam logic [61:0] WBOTH_I = IDLE_I & ~(62'hF << 34);
   localparam logic [61:0] ACC_I   = IDLE_I | (62'd1 << 60) | 62'h1;
   localparam logic [61:0] ADDR_I  = IDLE_I | (62'h155 << 7) | (62'h2AA << 20);

   inst_decode #(.col(8), .nij(36)) dut (
      .clk      (clk),
      .reset    (reset),
      .inst     (inst),
      .dec_ctrl (dec_ctrl),
      .dec_xmem (dec_xmem),
      .dec_pmem (dec_pmem),
      .dec_wmem (dec_wmem),
      .dec_mode (dec_mode),
      .phase    (phase),
      .load_cnt (load_cnt),
      .exec_cnt (exec_cnt),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic [61:0] value);
      inst = value;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      inst  = '0;
      repeat (10) apply_stimulus('0);
      check_output("rst_ctrl",  64'(dec_ctrl), 64'h0);
      check_output("rst_xmem",  64'(dec_xmem), 64'h1800);
      check_output("rst_pmem",  64'(dec_pmem), 64'h1800);
      check_output("rst_wmem",  64'(dec_wmem), 64'hF);
      check_output("rst_mode",  64'(dec_mode), 64'h0);
      check_output("rst_phase", 64'(phase),    64'd0);
      check_output("rst_lcnt",  64'(load_cnt), 64'd0);
      check_output("rst_ecnt",  64'(exec_cnt), 64'd0);
      check_output("rst_err",   64'(err),      64'd0);

      reset = 1'b0;
      apply_stimulus(IDLE_I);
      check_output("idle_phase", 64'(phase), 64'd0);
      check_output("idle_err",   64'(err),   64'd0);

      // Address fields pass straight through
      apply_stimulus(ADDR_I);
      check_output("addr_xmem",  64'(dec_xmem), 64'h1955);
      check_output("addr_pmem",  64'(dec_pmem), 64'h1AAA);
      check_output("addr_phase", 64'(phase),    64'd0);

      // Kernel load of exactly col beats
      for (int i = 1; i <= 8; i++) begin
         apply_stimulus(LOAD_I);
         check_output("kld_phase", 64'(phase),    64'd3);
         check_output("kld_cnt",   64'(load_cnt), 64'(i));
         check_output("kld_ctrl0", 64'(dec_ctrl[0]), 64'd1);
      end
      apply_stimulus(IDLE_I);
      check_output("kld_exit_phase", 64'(phase),       64'd0);
      check_output("kld_exit_cnt",   64'(load_cnt),    64'd8);
      check_output("kld_exit_ctrl0", 64'(dec_ctrl[0]), 64'd0);
      check_output("kld_exit_err",   64'(err),         64'd0);

      // Execute burst of exactly nij beats
      for (int i = 1; i <= 36; i++) begin
         apply_stimulus(EXEC_I);
         check_output("exe_phase", 64'(phase), 64'd5);
      end
      check_output("exe_cnt", 64'(exec_cnt), 64'd36);
      apply_stimulus(IDLE_I);
      check_output("exe_exit_phase", 64'(phase), 64'd0);
      check_output("exe_exit_err",   64'(err),   64'd0);

      // Short execute burst raises sticky err_exec
      repeat (35) apply_stimulus(EXEC_I);
      check_output("exe35_cnt", 64'(exec_cnt), 64'd35);
      check_output("exe35_err_before", 64'(err), 64'd0);
      apply_stimulus(IDLE_I);
      check_output("exe35_err", 64'(err), 64'b100);
      repeat (3) apply_stimulus(IDLE_I);
      check_output("exe35_sticky", 64'(err), 64'b100);
      reset = 1'b1;
      apply_stimulus(IDLE_I);
      check_output("exe35_rst_err", 64'(err), 64'd0);
      reset = 1'b0;

      // Xmem fill with a trailing L0 write
      for (int i = 1; i <= 35; i++) begin
         apply_stimulus(XFL_I);
         check_output("xfl_phase", 64'(phase), 64'd4);
      end
      apply_stimulus(TRAIL_I);
      check_output("xfl_trail_phase", 64'(phase), 64'd4);
      apply_stimulus(IDLE_I);
      check_output("xfl_exit_phase", 64'(phase), 64'd0);
      check_output("xfl_exit_err",   64'(err),   64'd0);

      apply_stimulus(XWR_I);
      check_output("xwr_phase", 64'(phase), 64'd1);
      apply_stimulus(ACC_I);
      check_output("acc_phase", 64'(phase),    64'd6);
      check_output("acc_mode",  64'(dec_mode), 64'b01);
      apply_stimulus(IDLE_I);
      check_output("acc_exit_err", 64'(err), 64'd0);

      // L0 read/write clash during xmem fill
      apply_stimulus(XFL_I);
      apply_stimulus(XFL_I | 62'h8);
      check_output("xfl_clash_err", 64'(err), 64'b001);
      reset = 1'b1;
      apply_stimulus(IDLE_I);
      reset = 1'b0;

      // load+execute in the same cycle: EXE wins, conflict flagged, then short-burst exit
      apply_stimulus(IDLE_I | 62'h3);
      check_output("le_phase", 64'(phase),    64'd5);
      check_output("le_err",   64'(err),      64'b001);
      check_output("le_cnt",   64'(exec_cnt), 64'd1);
      apply_stimulus(IDLE_I);
      check_output("le_exit_err", 64'(err), 64'b101);
      reset = 1'b1;
      apply_stimulus(IDLE_I);
      reset = 1'b0;

      // Both weight banks written at once
      apply_stimulus(WBOTH_I);
      check_output("wboth_phase", 64'(phase),          64'd2);
      check_output("wboth_err",   64'(err),            64'b001);
      check_output("wboth_wmem",  64'(dec_wmem[3:0]),  64'h0);
      reset = 1'b1;
      apply_stimulus(IDLE_I);
      reset = 1'b0;

      // Over-long kernel load saturates at 15 and flags err_kload
      for (int i = 1; i <= 17; i++) begin
         apply_stimulus(LOAD_I);
         check_output("sat_cnt", 64'(load_cnt), 64'((i > 15) ? 15 : i));
      end
      apply_stimulus(IDLE_I);
      check_output("sat_exit_err", 64'(err), 64'b010);
      reset = 1'b1;
      apply_stimulus(IDLE_I);
      reset = 1'b0;

      // Re-entry restarts the counter, reset mid-burst aborts without error
      repeat (3) apply_stimulus(LOAD_I);
      check_output("abort_cnt3", 64'(load_cnt), 64'd3);
      reset = 1'b1;
      apply_stimulus(LOAD_I);
      check_output("abort_phase", 64'(phase),    64'd0);
      check_output("abort_cnt",   64'(load_cnt), 64'd0);
      check_output("abort_err",   64'(err),      64'd0);
      reset = 1'b0;
      apply_stimulus(IDLE_I);
      check_output("post_abort_phase", 64'(phase), 64'd0);
      check_output("post_abort_err",   64'(err),   64'd0);
      apply_stimulus(LOAD_I);
      check_output("post_abort_kld", 64'(phase), 64'd3);
      check_output("post_abort_cnt", 64'(load_cnt), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_decode.md
INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 Parameter col, default 8: number of kernel-load cycles expected per kernel load.
REQ-002 Parameter nij, default 36: number of execute cycles expected per execute burst.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 inst  input  62  instruction word from the core instruction bus; layout fixed in REQ-012.
REQ-006 dec_ctrl  output  7  registered {ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load} = inst[6:0].
REQ-007 dec_xmem  output  13  registered {CEN, WEN, A[10:0]} = inst[19:7].
REQ-008 dec_pmem  output  14  registered {acc, CEN, WEN, A[10:0]} = inst[33:20].
REQ-009 dec_wmem  output  26  registered {A_1, A_0, CEN_1, WEN_1, CEN_0, WEN_0} = inst[59:34].
REQ-010 dec_mode  output  2  registered {Choice, Start_acc} = inst[61:60].
REQ-011 phase  output  3  current phase code (REQ-015); load_cnt, exec_cnt outputs 4 and 6 bits; err output 3 bits, sticky {err_exec, err_kload, err_conflict}.

Function
REQ-012 Bit map: [61] Choice, [60] Start_acc, [59:49] A_wmem_1, [48:38] A_wmem_0, [37] CEN_wmem_1, [36] WEN_wmem_1, [35] CEN_wmem_0, [34] WEN_wmem_0, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6:0] as REQ-006; all CEN/WEN are active-low.
REQ-013 All dec_* outputs shall equal the inst fields sampled at the previous posedge (latency exactly 1 cycle), with no gating by phase or errors.
REQ-014 Per-cycle activity class shall be resolved by priority: ACC (Start_acc|acc) > EXE (execute) > KLD (load) > XFL (CEN_xmem=0, WEN_xmem=1) > XWR (CEN_xmem=0, WEN_xmem=0) > WLD (CEN_wmem_0=0 or CEN_wmem_1=0) > none.
REQ-015 Phase codes: IDLE=0, XWR=1, WLD=2, KLD=3, XFL=4, EXE=5, ACC=6; code 7 unused; if reached, next cycle shall be IDLE.
REQ-016 Next phase = activity class; class "none" with l0_wr=1 while in WLD or XFL shall hold that phase (trailing L0 write); otherwise class "none" gives IDLE.
REQ-017 load_cnt shall clear on entry to KLD, increment once per cycle in KLD with load=1, and saturate at 15.
REQ-018 exec_cnt shall clear on entry to EXE, increment once per cycle with execute=1, and saturate at 63.
REQ-019 On exit from KLD (next phase differs), load_cnt != col shall set err_kload.
REQ-020 On exit from EXE, exec_cnt != nij shall set err_exec.
REQ-021 Exit-check comparison shall use the counter value including the final cycle of the phase.
REQ-022 err_conflict shall be set in any cycle where load=1 and execute=1.
REQ-023 err_conflict shall also be set in any cycle where both wmem banks are written (CEN_wmem_0=WEN_wmem_0=CEN_wmem_1=WEN_wmem_1=0).
REQ-024 err_conflict shall also be set in any cycle where l0_rd=1 and l0_wr=1 while the phase is XFL.
REQ-025 Error bits shall be sticky and cleared only by reset.
REQ-026 Re-entering a phase after leaving it shall restart its counter from 0.

Reset
REQ-027 While reset=1 at posedge: phase=IDLE, load_cnt=0, exec_cnt=0, err=0, dec_ctrl=0, dec_mode=0, all addresses 0, all CEN/WEN outputs 1, acc=0.
REQ-028 Reset asserted mid-phase shall abort the phase without setting any error bit; the first post-reset cycle evaluates inst normally.

Verification
REQ-029 Reset 10 cycles with inst=0 -> all outputs at REQ-027 values; phase=0, err=0.
REQ-030 Drive 8 cycles load=1, then idle -> phase=3 for 8 cycles; load_cnt=8; err=0; dec_ctrl[0] lags inst[0] by one cycle.
REQ-031 Drive 36 cycles execute=1 with l0_rd=1, then idle -> phase=5; exec_cnt=36; err_exec=0. Repeat with 35 cycles -> err_exec=1 on exit and remains set until reset.
REQ-032 Drive 35 cycles CEN_xmem=0, WEN_xmem=1, l0_wr=1, then 1 cycle with only l0_wr=1 -> phase holds 4 through the trailing cycle, then returns to 0.
REQ-033 Drive load=1 and execute=1 together for one cycle -> phase=5; err_conflict=1. Separately, drive all wmem CEN/WEN=0 for one cycle -> err_conflict=1.
REQ-034 Assert reset during cycle 4 of a KLD burst -> phase=0, load_cnt=0, err=0 after reset; no err_kload is raised.
